// File: rtl/mux_scan_pkg.sv
// Shared definitions for the mux scan sequencer: channel count, select width, FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mux_scan_pkg;

    localparam int NCH   = 8;
    localparam int SEL_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/mux_scan_next_ch.sv
// Priority encoder: next-higher enabled channel, lowest enabled channel, last-channel flag.
// Latency: purely combinational.
// Backpressure: none.
module mux_scan_next_ch
    import mux_scan_pkg::*;
(
    input  logic [NCH-1:0]   mask,
    input  logic [SEL_W-1:0] cur,
    output logic [SEL_W-1:0] nxt,
    output logic [SEL_W-1:0] lowest,
    output logic             is_last
);

    // Scan from the top down so the last hit is the smallest qualifying channel.
    always_comb begin
        nxt     = '0;
        lowest  = '0;
        is_last = 1'b1;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (mask[k]) begin
                lowest = SEL_W'(k);
            end
            if (mask[k] && (k > int'(cur))) begin
                nxt     = SEL_W'(k);
                is_last = 1'b0;
            end
        end
    end

endmodule

// File: rtl/mux_scan_sequencer.sv
// Steps an 8:1 mux select over enabled channels, waits SETTLE cycles, captures mux_y and offers it downstream.
// Latency: sample valid SETTLE cycles after the select changes; one sample per SETTLE+1 cycles at full rate.
// Backpressure: out_valid/out_data/out_ch and the select hold while out_ready is low; the scan stalls in HOLD.
module mux_scan_sequencer
    import mux_scan_pkg::*;
#(
    parameter int N      = 4,
    parameter int SETTLE = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           cont,
    input  logic [7:0]     ch_mask,
    input  logic [N-1:0]   mux_y,
    output logic           s0,
    output logic           s1,
    output logic           s2,
    output logic [N-1:0]   out_data,
    output logic [2:0]     out_ch,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           busy,
    output logic           done
);

    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);

    state_t             state_q,     state_d;
    logic [SEL_W-1:0]   sel_q,       sel_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic [NCH-1:0]     mask_q,      mask_d;
    logic [N-1:0]       out_data_q,  out_data_d;
    logic [SEL_W-1:0]   out_ch_q,    out_ch_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q,      busy_d;
    logic               done_q,      done_d;

    logic [NCH-1:0]     enc_mask;
    logic [SEL_W-1:0]   enc_nxt;
    logic [SEL_W-1:0]   enc_lowest;
    logic               enc_is_last;

    // In IDLE the encoder looks at the live mask so the first channel is known on the accepting edge.
    assign enc_mask = (state_q == ST_IDLE) ? ch_mask : mask_q;

    mux_scan_next_ch u_next_ch (
        .mask    (enc_mask),
        .cur     (sel_q),
        .nxt     (enc_nxt),
        .lowest  (enc_lowest),
        .is_last (enc_is_last)
    );

    // Next-state and next-output computation for the scan FSM.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        cnt_d       = cnt_q;
        mask_d      = mask_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mask_d = ch_mask;
                    busy_d = 1'b1;
                    if (ch_mask != '0) begin
                        sel_d   = enc_lowest;
                        cnt_d   = '0;
                        state_d = ST_SETTLE;
                    end else begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_SETTLE: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d       = '0;
                    out_data_d  = mux_y;
                    out_ch_d    = sel_q;
                    out_valid_d = 1'b1;
                    state_d     = ST_HOLD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    if (!enc_is_last) begin
                        sel_d   = enc_nxt;
                        state_d = ST_SETTLE;
                    end else if (cont) begin
                        // Wrap to the lowest channel of the mask latched at start.
                        sel_d   = enc_lowest;
                        state_d = ST_SETTLE;
                    end else begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; synchronous reset abandons any scan in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            sel_q       <= '0;
            cnt_q       <= '0;
            mask_q      <= '0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            cnt_q       <= cnt_d;
            mask_q      <= mask_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign s0        = sel_q[0];
    assign s1        = sel_q[1];
    assign s2        = sel_q[2];
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Bench for mux_scan_sequencer with an 8:1 mux model whose input k carries value k.
// Latency: n/a.
// Backpressure: out_ready driven by the stimulus sequences.
module tb_mux_scan_sequencer;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         cont;
    logic [7:0]   ch_mask;
    logic [N-1:0] mux_y;
    logic         s0, s1, s2;
    logic [N-1:0] out_data;
    logic [2:0]   out_ch;
    logic         out_valid;
    logic         out_ready;
    logic         busy;
    logic         done;
    logic [2:0]   sel;

    mux_scan_sequencer #(.N(N), .SETTLE(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .cont      (cont),
        .ch_mask   (ch_mask),
        .mux_y     (mux_y),
        .s0        (s0),
        .s1        (s1),
        .s2        (s2),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // 8:1 mux model: input k carries the value k.
    logic [N-1:0] mux_in [8];
    initial for (int k = 0; k < 8; k++) mux_in[k] = N'(k);
    assign sel   = {s2, s1, s0};
    assign mux_y = mux_in[sel];

    typedef struct {
        logic [2:0]   ch;
        logic [N-1:0] data;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        logic [7:0] mask;
        int         exp_n;
        logic [7:0] exp_visit;
    } vec_t;
    vec_t vecs[5];

    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    int         last_hs = -1;
    int         hs_cnt  = 0;
    int         done_cnt = 0;
    bit         gap_chk = 0;
    logic [7:0] visited = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] lowest_ch(input logic [7:0] m);
        logic [2:0] r;
        r = '0;
        for (int k = 7; k >= 0; k--) if (m[k]) r = 3'(k);
        return r;
    endfunction

    task automatic push_mask(input logic [7:0] m);
        exp_t e;
        for (int k = 0; k < 8; k++) begin
            if (m[k]) begin
                e.ch   = 3'(k);
                e.data = N'(k);
                exp_q.push_back(e);
            end
        end
    endtask

    // Returns one tick after the accepting edge E0.
    task automatic pulse_start(input logic [7:0] m);
        @(negedge clk);
        #1 start = 1'b1;
        ch_mask  = m;
        @(posedge clk);
        #1 start = 1'b0;
        ch_mask  = ~m;
    endtask

    task automatic wait_done(input int d0, input int budget);
        bit got;
        got = 0;
        for (int i = 0; i < budget && !got; i++) begin
            @(posedge clk);
            got = (done_cnt > d0);
        end
        check("done_timeout", 32'(got), 32'd1);
    endtask

    task automatic wait_valid(output bit ok);
        ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (out_valid) ok = 1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        if (!ok) check("valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic handshake_one();
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    // Scoreboard monitor: pops on every observed transfer, tracks visited selects and done pulses.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (busy) visited = visited | (8'h01 << sel);
        if (done) done_cnt++;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexp_xfer", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("xfer_ch", 32'(out_ch), 32'(e.ch));
                check("xfer_data", 32'(out_data), 32'(e.data));
            end
            if (gap_chk && last_hs >= 0) check("xfer_gap", 32'(cyc - last_hs), 32'd3);
            last_hs = cyc;
            hs_cnt++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  d0;
        bit  ok;
        logic [2:0] lo;

        vecs[0] = '{mask: 8'hFF, exp_n: 8, exp_visit: 8'hFF};
        vecs[1] = '{mask: 8'hA5, exp_n: 4, exp_visit: 8'hA5};
        vecs[2] = '{mask: 8'h01, exp_n: 1, exp_visit: 8'h01};
        vecs[3] = '{mask: 8'h80, exp_n: 1, exp_visit: 8'h80};
        vecs[4] = '{mask: 8'h3C, exp_n: 4, exp_visit: 8'h3C};

        rst_n = 1'b0; start = 1'b0; cont = 1'b0; ch_mask = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_sel", 32'(sel), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_ch", 32'(out_ch), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        #1 rst_n = 1'b1;

        // Single-pass scans with ready tied high, one table row per mask.
        for (int v = 0; v < 5; v++) begin
            d0 = done_cnt; visited = '0; hs_cnt = 0; last_hs = -1;
            gap_chk = 1; cont = 1'b0; out_ready = 1'b1;
            push_mask(vecs[v].mask);
            lo = lowest_ch(vecs[v].mask);
            pulse_start(vecs[v].mask);
            @(negedge clk);
            check("tbl_busy_e0", 32'(busy), 32'd1);
            check("tbl_sel_e0", 32'(sel), 32'(lo));
            check("tbl_valid_e0", 32'(out_valid), 32'd0);
            @(negedge clk);
            check("tbl_valid_e1", 32'(out_valid), 32'd0);
            @(negedge clk);
            check("tbl_valid_e2", 32'(out_valid), 32'd1);
            // A start while busy must be ignored.
            #1 start = 1'b1;
            ch_mask = 8'h02;
            @(posedge clk);
            #1 start = 1'b0;
            wait_done(d0, 200);
            repeat (2) @(negedge clk);
            #1;
            check("tbl_count", 32'(hs_cnt), 32'(vecs[v].exp_n));
            check("tbl_visit", 32'(visited), 32'(vecs[v].exp_visit));
            check("tbl_q_empty", 32'(exp_q.size()), 32'd0);
            check("tbl_done_once", 32'(done_cnt - d0), 32'd1);
            check("tbl_busy_end", 32'(busy), 32'd0);
        end

        // Backpressure on channel 2: outputs and select hold until ready rises.
        gap_chk = 0; hs_cnt = 0; d0 = done_cnt; out_ready = 1'b0;
        push_mask(8'hFF);
        pulse_start(8'hFF);
        for (int g = 0; g < 20 && hs_cnt < 8; g++) begin
            wait_valid(ok);
            if (!ok) break;
            if (out_ch == 3'd2) begin
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    check("bp_valid", 32'(out_valid), 32'd1);
                    check("bp_data", 32'(out_data), 32'd2);
                    check("bp_sel", 32'(sel), 32'd2);
                end
                @(posedge clk);
                #1 handshake_one();
                @(negedge clk);
                check("bp_sel_next", 32'(sel), 32'd3);
                check("bp_valid_next", 32'(out_valid), 32'd0);
            end else begin
                handshake_one();
            end
        end
        wait_done(d0, 100);
        #1;
        check("bp_count", 32'(hs_cnt), 32'd8);
        check("bp_q_empty", 32'(exp_q.size()), 32'd0);

        // Empty mask after reset: immediate done, no sample, select stays 000.
        @(negedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1; hs_cnt = 0; d0 = done_cnt;
        pulse_start(8'h00);
        @(negedge clk);
        check("empty_done", 32'(done), 32'd1);
        check("empty_busy", 32'(busy), 32'd1);
        check("empty_valid", 32'(out_valid), 32'd0);
        check("empty_sel", 32'(sel), 32'd0);
        @(negedge clk);
        check("empty_done_low", 32'(done), 32'd0);
        check("empty_busy_low", 32'(busy), 32'd0);
        check("empty_sel2", 32'(sel), 32'd0);
        #1;
        check("empty_no_xfer", 32'(hs_cnt), 32'd0);

        // Continuous mode on channels 0 and 7; cont drops during the third pass.
        visited = '0; hs_cnt = 0; last_hs = -1; gap_chk = 1; d0 = done_cnt;
        for (int p = 0; p < 3; p++) push_mask(8'h81);
        cont = 1'b1;
        pulse_start(8'h81);
        for (int i = 0; i < 100 && hs_cnt < 5; i++) @(posedge clk);
        #1 cont = 1'b0;
        wait_done(d0, 100);
        repeat (2) @(negedge clk);
        #1;
        check("cont_count", 32'(hs_cnt), 32'd6);
        check("cont_q_empty", 32'(exp_q.size()), 32'd0);
        check("cont_visit", 32'(visited), 32'h81);
        check("cont_done_once", 32'(done_cnt - d0), 32'd1);

        // Reset during HOLD of channel 4, then a clean restart.
        gap_chk = 0; hs_cnt = 0; out_ready = 1'b0;
        push_mask(8'hFF);
        pulse_start(8'hFF);
        for (int g = 0; g < 10; g++) begin
            wait_valid(ok);
            if (!ok || out_ch == 3'd4) break;
            handshake_one();
        end
        check("rr_hold_ch", 32'(out_ch), 32'd4);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rr_sel", 32'(sel), 32'd0);
        check("rr_valid", 32'(out_valid), 32'd0);
        check("rr_data", 32'(out_data), 32'd0);
        check("rr_ch", 32'(out_ch), 32'd0);
        check("rr_busy", 32'(busy), 32'd0);
        check("rr_done", 32'(done), 32'd0);
        #1;
        check("rr_hs_before", 32'(hs_cnt), 32'd4);
        exp_q.delete();
        hs_cnt = 0; last_hs = -1; gap_chk = 1; out_ready = 1'b1; d0 = done_cnt;
        push_mask(8'hFF);
        pulse_start(8'hFF);
        @(negedge clk);
        check("rr_restart_busy", 32'(busy), 32'd1);
        check("rr_restart_sel", 32'(sel), 32'd0);
        wait_done(d0, 100);
        #1;
        check("rr_count", 32'(hs_cnt), 32'd8);
        check("rr_q_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux_scan_sequencer.md
Name: mux_scan_sequencer

Overview:
- Sequential controller that drives the select lines of the team's 8:1 N-bit data mux and consumes its output `y`.
- Scans enabled channels in ascending order and waits a programmable settle time after each select change.
- Registers each muxed word and hands it downstream with a valid/ready handshake, tagged with its channel number.
- Supports single-pass and continuous scanning.

Parameters:
- N, 4, data width; must match the mux width.
- SETTLE, 2, cycles `s2..s0` are held before `mux_y` is captured; minimum 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle request to begin a scan; ignored while busy.
- cont  in  1  continuous mode; sampled at each pass end.
- ch_mask  in  8  channel enables, bit k = channel k; latched on accepted start.
- mux_y  in  N  output of the 8:1 mux.
- s0  out  1  mux select bit 0.
- s1  out  1  mux select bit 1.
- s2  out  1  mux select bit 2 (MSB).
- out_data  out  N  captured sample.
- out_ch  out  3  channel index of out_data.
- out_valid  out  1  sample available.
- out_ready  in  1  downstream accepts sample.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse at scan completion.

Behaviour:
- Reset (rst_n low at a rising edge) forces state IDLE on that edge, even mid-scan:
  - Outputs: `s2..s0` = 000, out_data = 0, out_ch = 0, out_valid = 0, busy = 0, done = 0.
  - Internal: settle counter = 0, latched mask = 0.
  - Any in-flight sample is discarded.
- FSM states: IDLE, SETTLE, HOLD, DONE.
- IDLE:
  - start = 1 with ch_mask ≠ 0: latch mask, drive `{s2,s1,s0}` = lowest enabled channel, busy = 1, go to SETTLE.
  - start = 1 with ch_mask = 0: go to DONE with busy = 1; no sample is produced.
- SETTLE:
  - Select held constant; counter counts SETTLE cycles.
  - On the rising edge ending the SETTLE-th cycle: out_data ← mux_y, out_ch ← current select, out_valid ← 1, go to HOLD.
  - With SETTLE = 2 and start accepted at edge E0: select is valid after E0, capture happens at E2, out_valid is high from E2.
- HOLD:
  - out_valid, out_data, out_ch and select are stable while out_ready = 0.
  - Handshake is out_valid & out_ready at an edge; out_ready may already be high, so the transfer completes on the first HOLD cycle.
  - On handshake, out_valid ← 0, then:
    - Another enabled channel above the current one: select ← next enabled channel, go to SETTLE.
    - Current channel is the highest enabled and cont = 1: wrap select to the lowest enabled channel (latched mask), go to SETTLE.
    - Current channel is the highest enabled and cont = 0: go to DONE.
- DONE: done = 1 for exactly one cycle, busy ← 0, go to IDLE. Select retains its last value.
- Mask handling:
  - ch_mask changes during a scan have no effect.
  - In continuous mode the latched mask persists until stop; a new mask requires cont = 0 and a new start.
- start during busy is ignored; no queuing.
- Single enabled channel with cont = 1: repeats the same channel, re-settling each time.
- Throughput with out_ready tied high: one sample per SETTLE + 1 cycles.

Decomposition:
- Shared package mux_scan_pkg holds:
  - NCH = 8 and SEL_W = 3.
  - State enum {IDLE, SETTLE, HOLD, DONE}.
- One combinational sub-module, mux_scan_next_ch:
  - Inputs: 8-bit mask and current channel.
  - Outputs: next-higher enabled channel, lowest enabled channel, and an is_last flag.
  - Implemented as a priority encoder.

Test Plan:
Bench instantiates the existing 8:1 mux with N = 4 and i_k = k, connects its `y` to mux_y, and uses SETTLE = 2 unless noted.
1. ch_mask = 8'hFF, cont = 0, out_ready = 1, one start pulse -> eight transfers (out_ch, out_data) = (0,0)…(7,7), 3 cycles apart; done pulses once after channel 7; busy then falls.
2. ch_mask = 8'hA5 -> transfers only channels 0, 2, 5, 7 with data 0, 2, 5, 7; select never visits 1, 3, 4 or 6.
3. ch_mask = 8'hFF, out_ready held low for 5 cycles while out_ch = 2 -> out_valid, out_data = 2 and `s2..s0` = 010 are stable for those cycles; channel 3 settles only after out_ready rises.
4. ch_mask = 0 with start -> done pulses one cycle after start, out_valid never asserts, select stays 000.
5. ch_mask = 8'h81, cont = 1, then cont dropped during the third pass -> sequence 0, 7, 0, 7, 0, 7, then done; the wrap from 7 back to 0 is observed.
6. rst_n low for 1 cycle during HOLD of channel 4 with out_ready = 0 -> the next cycle shows all outputs at reset values and state IDLE; a following start restarts the scan from channel 0.
